// File: rtl/main_memory_responder.sv
// Shared main-memory responder: single arbitrated read/write port, a low-priority
// debug port sharing the write path, and a post-reset clear sweep.
module main_memory_responder #(
   parameter int unsigned ADDR_BITS      = 6,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter bit          CLEAR_ON_RESET = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  main_mem_we,
   input  logic [ADDR_BITS-1:0]  main_mem_addr,
   input  logic [DATA_WIDTH-1:0] main_mem_in,
   output logic [DATA_WIDTH-1:0] main_mem_out,
   output logic                  main_mem_ready,
   input  logic                  dbg_req,
   input  logic                  dbg_we,
   input  logic [ADDR_BITS-1:0]  dbg_addr,
   input  logic [DATA_WIDTH-1:0] dbg_in,
   output logic [DATA_WIDTH-1:0] dbg_out,
   output logic                  dbg_ack
);

   typedef enum logic [1:0] {
      S_CLEAR,
      S_IDLE,
      S_DBG_ACK
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_BITS-1:0]    clear_ptr_q, clear_ptr_d;
   logic [DATA_WIDTH-1:0]   main_out_q, main_out_d;
   logic [DATA_WIDTH-1:0]   dbg_out_q, dbg_out_d;
   logic                    ready_q, ready_d;
   logic [DATA_WIDTH-1:0]   mem_q [2**ADDR_BITS];

   logic                    wr_en;
   logic [ADDR_BITS-1:0]    wr_addr;
   logic [DATA_WIDTH-1:0]   wr_data;

   always_comb begin
      state_d     = state_q;
      clear_ptr_d = clear_ptr_q;
      dbg_out_d   = dbg_out_q;
      wr_en       = 1'b0;
      wr_addr     = main_mem_addr;
      wr_data     = main_mem_in;

      unique case (state_q)
         S_CLEAR: begin
            wr_en       = 1'b1;
            wr_addr     = clear_ptr_q;
            wr_data     = '0;
            clear_ptr_d = clear_ptr_q + ADDR_BITS'(1);
            if (&clear_ptr_q) state_d = S_IDLE;
         end
         S_IDLE: begin
            if (main_mem_we) begin
               wr_en = 1'b1;
            end else if (dbg_req) begin
               // Debug op only owns the write path when the main port is not writing.
               state_d = S_DBG_ACK;
               if (dbg_we) begin
                  wr_en   = 1'b1;
                  wr_addr = dbg_addr;
                  wr_data = dbg_in;
               end else begin
                  dbg_out_d = mem_q[dbg_addr];
               end
            end
         end
         S_DBG_ACK: begin
            state_d = S_IDLE;
            wr_en   = main_mem_we;
         end
         default: state_d = S_CLEAR;
      endcase

      // Write-first: a same-cycle write to the read address (main or debug) bypasses the array.
      if (state_q == S_CLEAR)
         main_out_d = '0;
      else if (wr_en && (wr_addr == main_mem_addr))
         main_out_d = wr_data;
      else
         main_out_d = mem_q[main_mem_addr];

      ready_d = (state_d != S_CLEAR);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
         clear_ptr_q <= '0;
         main_out_q  <= '0;
         dbg_out_q   <= '0;
         ready_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         clear_ptr_q <= clear_ptr_d;
         main_out_q  <= main_out_d;
         dbg_out_q   <= dbg_out_d;
         ready_q     <= ready_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en && !rst) mem_q[wr_addr] <= wr_data;
   end

   assign main_mem_out   = main_out_q;
   assign main_mem_ready = ready_q;
   assign dbg_out        = dbg_out_q;
   assign dbg_ack        = (state_q == S_DBG_ACK);

endmodule
